// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
  localparam logic [31:0] PC_STEP_C   = 32'h0000_0004;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

  // Instruction addresses are always word aligned; low two bits are forced to zero.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, fetches one instruction at a time from instruction memory
// and fills the IF/ID register, honouring stall, flush and execute-stage redirects.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic        instr_valid
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] next_pc_out_q, next_pc_out_d;
  logic        instr_valid_q, instr_valid_d;

  logic        load_s;
  logic [31:0] load_instr_s;
  logic [31:0] load_pc_s;
  logic [31:0] redirect_target_s;

  assign redirect_target_s = align_word(redirect_pc);
  assign imem_req_valid    = (state_q == IF_REQ) && !redirect_valid && !reset;
  assign imem_addr         = pc_q;

  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign next_pc_out = next_pc_out_q;
  assign instr_valid = instr_valid_q;

  // Fetch FSM: PC update, request handshake, response capture and redirect handling.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    drop_d       = drop_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    load_s       = 1'b0;
    load_instr_s = imem_rsp_data;
    load_pc_s    = fetch_pc_q;
    case (state_q)
      IF_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_target_s;
        end else if (imem_req_ready) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + PC_STEP_C;
          state_d    = IF_WAIT;
        end else begin
          state_d = IF_REQ;
        end
      end
      IF_WAIT: begin
        if (redirect_valid) begin
          // An in-flight response belongs to the wrong path: drop it now or when it lands.
          pc_d = redirect_target_s;
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = IF_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = IF_REQ;
          end else if (!stall && !flush) begin
            load_s  = 1'b1;
            state_d = IF_REQ;
          end else begin
            buf_instr_d = imem_rsp_data;
            buf_pc_d    = fetch_pc_q;
            state_d     = IF_HOLD;
          end
        end else begin
          state_d = IF_WAIT;
        end
      end
      IF_HOLD: begin
        load_instr_s = buf_instr_q;
        load_pc_s    = buf_pc_q;
        if (redirect_valid) begin
          pc_d    = redirect_target_s;
          state_d = IF_REQ;
        end else if (!stall && !flush) begin
          load_s  = 1'b1;
          state_d = IF_REQ;
        end else begin
          state_d = IF_HOLD;
        end
      end
      default: begin
        state_d = IF_REQ;
      end
    endcase
  end

  // IF/ID register: flush beats stall beats load; an idle cycle inserts a bubble.
  always_comb begin
    instr_d       = NOP_INSTR;
    pc_out_d      = 32'h0000_0000;
    next_pc_out_d = 32'h0000_0000;
    instr_valid_d = 1'b0;
    if (flush) begin
      instr_valid_d = 1'b0;
    end else if (stall) begin
      instr_d       = instr_q;
      pc_out_d      = pc_out_q;
      next_pc_out_d = next_pc_out_q;
      instr_valid_d = instr_valid_q;
    end else if (load_s) begin
      instr_d       = load_instr_s;
      pc_out_d      = load_pc_s;
      next_pc_out_d = load_pc_s + PC_STEP_C;
      instr_valid_d = 1'b1;
    end else begin
      instr_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IF_REQ;
      pc_q          <= align_word(RESET_PC);
      fetch_pc_q    <= 32'h0000_0000;
      drop_q        <= 1'b0;
      buf_instr_q   <= 32'h0000_0000;
      buf_pc_q      <= 32'h0000_0000;
      instr_q       <= NOP_INSTR;
      pc_out_q      <= 32'h0000_0000;
      next_pc_out_q <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      drop_q        <= drop_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc_q      <= buf_pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      next_pc_out_q <= next_pc_out_d;
      instr_valid_q <= instr_valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch addresses and IF/ID contents are
// queued by the stimulus and consumed by independent monitors.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] next_pc_out;
  logic        instr_valid;

  instr_fetch #(
    .RESET_PC (32'hFFFF_FFFC),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr         (instr),
    .pc_out        (pc_out),
    .next_pc_out   (next_pc_out),
    .instr_valid   (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } ifid_t;

  ifid_t       exp_q[$];
  logic [31:0] addr_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cycle = 0;
  logic        mon_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic        last_hs = 1'b0;
  logic [31:0] last_addr = 32'h0000_0000;
  ifid_t       last_seen;
  int          rsp_lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic push_ifid(input logic [31:0] i, input logic [31:0] p, input logic [31:0] n);
    ifid_t e;
    e.instr = i; e.pc = p; e.npc = n;
    exp_q.push_back(e);
  endtask

  // One clock: sample handshake mid-cycle, step the memory model after the edge.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    logic        st;
    @(negedge clk);
    hs = imem_req_valid && imem_req_ready;
    a  = imem_addr;
    st = stall;
    @(posedge clk);
    #1;
    cycle++;
    last_hs    = hs;
    last_addr  = a;
    stall_prev = st;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0000_0000;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (hs) begin
        pend = 1'b1; paddr = a; cnt = rsp_lat;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = paddr ^ 32'hA5A5_0000;
          pend = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_hs(input logic [31:0] a);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(last_hs && last_addr == a) && n < 64);
    if (!(last_hs && last_addr == a)) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_hs: no request for %h within %0d cycles", a, n);
    end
  endtask

  // Request monitor: every accepted fetch must match the next expected address.
  always @(negedge clk) begin
    if (mon_en && imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
      if (addr_q.size() == 0) begin
        chk("unexpected_req", imem_addr, 32'hDEAD_DEAD);
      end else begin
        chk("req_addr", imem_addr, addr_q.pop_front());
      end
    end
  end

  // IF/ID monitor: new instructions pop the scoreboard, stalled ones must hold, bubbles are NOPs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (instr_valid === 1'b1) begin
        if (stall_prev) begin
          chk("hold_instr", instr, last_seen.instr);
          chk("hold_pc", pc_out, last_seen.pc);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_ifid", pc_out, 32'hDEAD_DEAD);
        end else begin
          last_seen = exp_q.pop_front();
          chk("ifid_instr", instr, last_seen.instr);
          chk("ifid_pc", pc_out, last_seen.pc);
          chk("ifid_next_pc", next_pc_out, last_seen.npc);
        end
      end else begin
        chk("bubble_valid", {31'd0, instr_valid}, 32'd0);
        chk("bubble_instr", instr, NOP);
        chk("bubble_pc", pc_out | next_pc_out, 32'h0000_0000);
      end
    end
  end

  initial begin
    int c0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0000_0000;
    last_seen.instr = NOP; last_seen.pc = 32'h0; last_seen.npc = 32'h0;

    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_instr", instr, NOP);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // Test 1/2/3 traffic: wrap from 0xFFFFFFFC, then sequential to 0x40 (0x40 gets killed).
    addr_q.push_back(32'hFFFF_FFFC);
    push_ifid(32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
    for (int i = 0; i <= 16; i++) addr_q.push_back(32'(i * 4));
    for (int i = 0; i <= 15; i++) push_ifid(32'hA5A5_0000 | 32'(i * 4), 32'(i * 4), 32'(i * 4 + 4));

    reset = 1'b0;
    #1;
    chk("first_addr", imem_addr, 32'hFFFF_FFFC);
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);

    wait_hs(32'h0000_0000);
    c0 = cycle;
    wait_hs(32'h0000_0008);
    chk("throughput_cycles", 32'(cycle - c0), 32'd4);

    // Test 2: stall across the 0x10 response.
    wait_hs(32'h0000_000C);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc_hold", pc_out, 32'h0000_000C);
      if (i > 0) chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc", pc_out, 32'h0000_0010);
    chk("unstall_instr", instr, 32'hA5A5_0010);
    chk("after_stall_addr", imem_addr, 32'h0000_0014);

    // Test 3: redirect to 0x200 while waiting on 0x40.
    wait_hs(32'h0000_003C);
    rsp_lat = 3;
    wait_hs(32'h0000_0040);
    addr_q.push_back(32'h0000_0200);
    push_ifid(32'hA5A5_0200, 32'h0000_0200, 32'h0000_0204);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
    rsp_lat = 1;
    chk("redir_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    wait_hs(32'h0000_0200);

    // Test 4: flush+redirect (with stall) on the cycle the 0x204 response arrives.
    addr_q.push_back(32'h0000_0204);
    addr_q.push_back(32'h0000_0080);
    push_ifid(32'hA5A5_0080, 32'h0000_0080, 32'h0000_0084);
    tick();
    stall = 1'b1;
    tick();
    chk("pre_flush_pc", pc_out, 32'h0000_0200);
    flush = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    tick();
    chk("flush_valid", {31'd0, instr_valid}, 32'd0);
    chk("flush_instr", instr, NOP);
    chk("flush_next_pc", next_pc_out, 32'h0000_0000);
    flush = 1'b0; redirect_valid = 1'b0; stall = 1'b0; redirect_pc = 32'h0000_0000;
    #1;
    chk("post_flush_addr", imem_addr, 32'h0000_0080);
    wait_hs(32'h0000_0080);

    // Test 5: memory not ready for 5 cycles.
    imem_req_ready = 1'b0;
    tick();
    chk("t5_load_pc", pc_out, 32'h0000_0080);
    chk("t5_load_npc", next_pc_out, 32'h0000_0084);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("t5_addr_stable", imem_addr, 32'h0000_0084);
      chk("t5_bubble", {31'd0, instr_valid}, 32'd0);
    end

    // Test 6: reset while waiting on 0x84, then restart from RESET_PC with wrap.
    addr_q.push_back(32'h0000_0084);
    imem_req_ready = 1'b1;
    rsp_lat = 3;
    wait_hs(32'h0000_0084);
    tick();
    reset = 1'b1;
    tick();
    chk("rst2_instr", instr, NOP);
    chk("rst2_pc", pc_out, 32'h0000_0000);
    chk("rst2_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    rsp_lat = 1;
    addr_q.push_back(32'hFFFF_FFFC);
    addr_q.push_back(32'h0000_0000);
    addr_q.push_back(32'h0000_0004);
    push_ifid(32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
    push_ifid(32'hA5A5_0000, 32'h0000_0000, 32'h0000_0004);
    push_ifid(32'hA5A5_0004, 32'h0000_0004, 32'h0000_0008);
    reset = 1'b0;
    #1;
    chk("rst2_first_addr", imem_addr, 32'hFFFF_FFFC);
    wait_hs(32'hFFFF_FFFC);
    tick();
    chk("wrap_next_pc", next_pc_out, 32'h0000_0000);
    chk("wrap_fetch_addr", imem_addr, 32'h0000_0000);
    wait_hs(32'h0000_0004);
    imem_req_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    chk("ifid_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
